// File: rtl/music_sequencer.sv
// Melody sequencer: plays the ROUND or WRONG jingle from a small note ROM as a square wave,
// stepping notes on a divided tick and signalling start/completion to the round logic.
module music_sequencer #(
    parameter int unsigned TICK_DIV   = 5_000_000,
    parameter int unsigned NOTE_TICKS = 2,
    parameter int unsigned BASE_HALF  = 25_000,
    parameter int unsigned STEP_HALF  = 2_500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_round,
    input  logic       wrong,
    output logic       is_music_playing,
    output logic       reset_current_index,
    output logic [2:0] note_index,
    output logic       tone_out,
    output logic       done
);

    localparam int unsigned HalfMax = BASE_HALF + 14 * STEP_HALF;
    localparam int unsigned TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NtW     = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam int unsigned HalfW   = (HalfMax > 1) ? $clog2(HalfMax) : 1;

    localparam logic ModeRound = 1'b0;
    localparam logic ModeWrong = 1'b1;

    typedef enum logic {StIdle, StPlay} state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [NtW-1:0]   note_tick_q, note_tick_d;
    logic [2:0]       note_index_q, note_index_d;
    logic [HalfW-1:0] half_cnt_q, half_cnt_d;
    logic             tone_q, tone_d;
    logic             done_q, done_d;
    logic             rci_q, rci_d;

    logic        restart;
    logic        tick_strobe;
    logic        note_end;
    logic        last_note;
    logic [3:0]  code;
    logic [31:0] half_max;

    function automatic logic [3:0] note_code(input logic mode, input logic [2:0] idx);
        logic [3:0] c;
        c = 4'd0;
        if (mode == ModeWrong) begin
            case (idx)
                3'd0:    c = 4'd12;
                3'd1:    c = 4'd6;
                default: c = 4'd0;
            endcase
        end else begin
            case (idx)
                3'd0:    c = 4'd4;
                3'd1:    c = 4'd8;
                3'd2:    c = 4'd12;
                3'd3:    c = 4'd15;
                default: c = 4'd0;
            endcase
        end
        return c;
    endfunction

    // start_round is only honoured from IDLE or while ROUND is playing; wrong always restarts
    assign restart     = wrong || (start_round && (state_q == StIdle || mode_q == ModeRound));
    assign tick_strobe = (state_q == StPlay) && (tick_cnt_q == TickW'(TICK_DIV - 1));
    assign note_end    = tick_strobe && (note_tick_q == NtW'(NOTE_TICKS - 1));
    assign last_note   = (note_index_q == ((mode_q == ModeWrong) ? 3'd2 : 3'd3));
    assign code        = note_code(mode_q, note_index_q);
    assign half_max    = 32'(BASE_HALF) + (32'd15 - 32'(code)) * 32'(STEP_HALF) - 32'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            mode_q       <= ModeRound;
            tick_cnt_q   <= '0;
            note_tick_q  <= '0;
            note_index_q <= '0;
            half_cnt_q   <= '0;
            tone_q       <= 1'b0;
            done_q       <= 1'b0;
            rci_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            tick_cnt_q   <= tick_cnt_d;
            note_tick_q  <= note_tick_d;
            note_index_q <= note_index_d;
            half_cnt_q   <= half_cnt_d;
            tone_q       <= tone_d;
            done_q       <= done_d;
            rci_q        <= rci_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (restart) state_d = StPlay;
            StPlay: if (!restart && note_end && last_note) state_d = StIdle;
        endcase
    end

    always_comb begin
        mode_d       = mode_q;
        tick_cnt_d   = tick_cnt_q;
        note_tick_d  = note_tick_q;
        note_index_d = note_index_q;
        half_cnt_d   = half_cnt_q;
        tone_d       = tone_q;
        done_d       = 1'b0;
        rci_d        = 1'b0;
        if (restart) begin
            mode_d       = wrong ? ModeWrong : ModeRound;
            tick_cnt_d   = '0;
            note_tick_d  = '0;
            note_index_d = '0;
            half_cnt_d   = '0;
            tone_d       = 1'b0;
            rci_d        = !wrong;
        end else if (state_q == StPlay) begin
            tick_cnt_d = tick_strobe ? '0 : tick_cnt_q + TickW'(1);
            if (tick_strobe) begin
                note_tick_d = note_end ? '0 : note_tick_q + NtW'(1);
            end
            if (note_end) begin
                half_cnt_d   = '0;
                tone_d       = 1'b0;
                note_index_d = last_note ? 3'd0 : note_index_q + 3'd1;
                done_d       = last_note;
            end else if (code == 4'd0) begin
                half_cnt_d = '0;
                tone_d     = 1'b0;
            end else if (32'(half_cnt_q) == half_max) begin
                half_cnt_d = '0;
                tone_d     = !tone_q;
            end else begin
                half_cnt_d = half_cnt_q + HalfW'(1);
            end
        end
    end

    assign is_music_playing    = (state_q == StPlay);
    assign reset_current_index = rci_q;
    assign note_index          = note_index_q;
    assign tone_out            = tone_q;
    assign done                = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench: each request pushes the expected output-change events (cycle + output
// vector); a monitor pops and checks one entry whenever the DUT output vector changes.
module tb_music_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_round;
    logic       wrong;
    logic       is_music_playing;
    logic       reset_current_index;
    logic [2:0] note_index;
    logic       tone_out;
    logic       done;

    music_sequencer #(
        .TICK_DIV  (4),
        .NOTE_TICKS(2),
        .BASE_HALF (2),
        .STEP_HALF (1)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start_round        (start_round),
        .wrong              (wrong),
        .is_music_playing   (is_music_playing),
        .reset_current_index(reset_current_index),
        .note_index         (note_index),
        .tone_out           (tone_out),
        .done               (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;
    logic [6:0] prev_vec = '0;

    // vec = {playing, rci, note_index[2:0], tone, done}; offsets relative to request cycle
    int         round_off[11] = '{1, 2, 9, 17, 22, 25, 27, 29, 31, 33, 34};
    logic [6:0] round_vec[11] = '{7'b1100000, 7'b1000000, 7'b1000100, 7'b1001000, 7'b1001010,
                                  7'b1001100, 7'b1001110, 7'b1001100, 7'b1001110, 7'b0000001,
                                  7'b0000000};
    int         wrong_off[6]  = '{1, 6, 9, 17, 25, 26};
    logic [6:0] wrong_vec[6]  = '{7'b1000000, 7'b1000010, 7'b1000100, 7'b1001000, 7'b0000001,
                                  7'b0000000};

    function automatic logic [6:0] out_vec();
        return {is_music_playing, reset_current_index, note_index, tone_out, done};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        logic [6:0] v;
        ev_t e;
        v = out_vec();
        if (mon_en && v !== prev_vec) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change: cyc=%0d vec=%b, required no change (prev %b)",
                         cyc, v, prev_vec);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.vec !== v) begin
                    fails++;
                    $display("FAIL event: got cyc=%0d vec=%b, required cyc=%0d vec=%b",
                             cyc, v, e.cyc, e.vec);
                end
            end
        end
        prev_vec = v;
    end

    task automatic push_round(input int c0, input int max_off);
        for (int i = 0; i < 11; i++) begin
            if (round_off[i] <= max_off) exp_q.push_back('{c0 + round_off[i], round_vec[i]});
        end
    endtask

    task automatic push_wrong(input int c0);
        for (int i = 0; i < 6; i++) exp_q.push_back('{c0 + wrong_off[i], wrong_vec[i]});
    endtask

    // Called right after a negedge; holds the request for exactly one sampling edge.
    task automatic pulse(input logic sr, input logic wr, output int c0);
        c0 = cyc;
        start_round = sr;
        wrong = wr;
        @(negedge clock);
        start_round = 1'b0;
        wrong = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int c0;
        int c1;
        reset = 1'b1;
        start_round = 1'b0;
        wrong = 1'b0;
        idle(2);
        tests++;
        if (out_vec() !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, required 0000000", out_vec());
        end
        prev_vec = 7'b0;
        mon_en = 1'b1;
        // start_round during the third reset cycle must be ignored
        pulse(1'b1, 1'b0, c0);
        reset = 1'b0;
        idle(5);

        // ROUND melody
        pulse(1'b1, 1'b0, c0);
        push_round(c0, 100);
        idle(40);

        // WRONG melody
        pulse(1'b0, 1'b1, c0);
        push_wrong(c0);
        idle(30);

        // both requests together: wrong wins, no reset_current_index
        pulse(1'b1, 1'b1, c0);
        push_wrong(c0);
        idle(30);

        // abort ROUND at note 2 with wrong, then start_round during WRONG is ignored
        pulse(1'b1, 1'b0, c0);
        push_round(c0, 17);
        idle(18);
        pulse(1'b0, 1'b1, c1);
        push_wrong(c1);
        idle(9);
        pulse(1'b1, 1'b0, c0);
        idle(25);

        // reset during ROUND note 1, then a full ROUND afterwards
        pulse(1'b1, 1'b0, c0);
        push_round(c0, 9);
        idle(11);
        exp_q.push_back('{cyc + 1, 7'b0000000});
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(3);
        pulse(1'b1, 1'b0, c0);
        push_round(c0, 100);
        idle(40);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_event: got none, required cyc=%0d vec=%b", e.cyc, e.vec);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
# music_sequencer

Parametrised melody sequencer for the game's audio path. On a round start it plays a fixed "round" jingle; on a wrong answer it plays a fixed "wrong" jingle. It pulses `reset_current_index` so the round logic rewinds its sequence pointer. It divides the system clock into note ticks, steps through an internal note ROM, and drives a square-wave buzzer output. It sits between the game FSM (`start_round`, `wrong`) and the buzzer pin.

## Interface
- `TICK_DIV`, 5_000_000 — clocks per tick (0.1 s at 50 MHz); must be ≥1.
- `NOTE_TICKS`, 2 — ticks per note; must be ≥1.
- `BASE_HALF`, 25_000 — tone half-period, in clocks, for note code 15.
- `STEP_HALF`, 2_500 — added half-period per code step below 15.
- `clock` in 1 — system clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `start_round` in 1 — single-cycle request to play the ROUND melody.
- `wrong` in 1 — single-cycle request to play the WRONG melody.
- `is_music_playing` out 1 — high while a melody is in progress.
- `reset_current_index` out 1 — one-cycle pulse when the ROUND melody starts.
- `note_index` out 3 — index of the current note within the melody.
- `tone_out` out 1 — square wave to the buzzer; 0 during rests and idle.
- `done` out 1 — one-cycle pulse when a melody completes normally.

## Operation
- **Note ROM** (4-bit codes, 0 = rest):
  - ROUND, length 4: 4, 8, 12, 15.
  - WRONG, length 3: 12, 6, 0.
- **Tone mapping:** code n (1..15) has half-period H(n) = BASE_HALF + (15−n)·STEP_HALF clocks.
- **States:** IDLE and PLAY. A 1-bit `mode` register holds ROUND or WRONG.
- **IDLE → PLAY:** on `start_round` or `wrong`.
  - `wrong` selects WRONG; `start_round` alone selects ROUND.
  - If both are high in the same cycle, `wrong` wins.
- **Entering PLAY clears** the tick counter, the tick count within the note, `note_index` and the half-period counter.
- **Tick counter:** counts 0..TICK_DIV−1 in PLAY only. The tick strobe is high when the count equals TICK_DIV−1.
- **Note advance:** after NOTE_TICKS strobes, `note_index` increments.
  - On the last note of the melody, the block returns to IDLE instead and pulses `done`.
- **Requests during PLAY:**
  - `wrong` aborts any melody and restarts as WRONG from index 0. No `done` pulse is issued for the aborted melody.
  - `start_round` during ROUND restarts ROUND and re-pulses `reset_current_index`.
  - `start_round` during WRONG is ignored.
- **Tone generator:**
  - The half-period counter counts 0..H(n)−1; `tone_out` toggles at H(n)−1.
  - The counter and `tone_out` clear to 0 on every note change and on entry to PLAY.
  - For code 0, or in IDLE, `tone_out` is held at 0.
- **Widths:** all counters are sized with $clog2 of their terminal value + 1. The H(n) arithmetic is done at 32 bits, with no overflow for legal parameters.

## Timing
- **Reset values:** state IDLE; `is_music_playing`, `reset_current_index`, `note_index`, `tone_out` and `done` all 0; every counter 0.
- **Reset mid-melody** returns the block to IDLE on the next edge with no `done` pulse.
- **Latency:**
  - A request sampled at edge k gives `is_music_playing`=1 and `note_index`=0 after edge k.
  - For ROUND, `reset_current_index`=1 for exactly the cycle after edge k.
- **Note length:** each note lasts TICK_DIV·NOTE_TICKS cycles.
- **End of melody:** `done` and `is_music_playing`=0 assert in the same cycle, one melody length after the start cycle.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
Settings for all scenarios: TICK_DIV=4, NOTE_TICKS=2, BASE_HALF=2, STEP_HALF=1. Each note is therefore 8 cycles.

1. **Reset:** hold `reset` 3 cycles → all outputs 0.
   - A `start_round` pulse while `reset`=1 is ignored.
2. **ROUND melody:** pulse `start_round` at cycle 0.
   - `reset_current_index`=1 only in cycle 1.
   - `note_index` is 0,1,2,3 at cycles 1,9,17,25.
   - `done`=1 at cycle 33, with `is_music_playing` falling the same cycle.
   - During note 3 (code 15), `tone_out` toggles every 2 cycles.
3. **WRONG melody:** pulse `wrong`.
   - During note 0 (code 12, H=5), `tone_out` toggles every 5 cycles.
   - During note 2 (rest), `tone_out` stays 0.
   - `done` fires 24 cycles after the melody starts.
   - `reset_current_index` never asserts.
4. **Priority:** `start_round` and `wrong` high in the same cycle → WRONG melody plays and `reset_current_index` stays 0.
5. **Abort and ignore:**
   - `wrong` at `note_index`=2 of ROUND → WRONG restarts at index 0, with no `done` pulse.
   - A later `start_round` during that WRONG melody is ignored; WRONG completes normally.
6. **Reset mid-melody:** assert `reset` during ROUND note 1 → IDLE next cycle, `tone_out`=0, no `done` pulse.
   - A new `start_round` then plays the full 33-cycle sequence.
